// File: rtl/lab_router_config_loader.sv
// -----------------------------------------------------------------------------
// lab_router_config_loader
// Serial loader for the PIA-to-LAB router routing-bit field. Bits arrive one
// per cycle over a valid/ready handshake and are assembled in a shadow
// register. A complete frame is copied to config_out in a single edge, so the
// router never observes a partially loaded configuration.
//
// Optional feature: define LAB_ROUTER_CONFIG_PARITY_EN to append one even
// parity bit to every frame. A frame whose parity fails is dropped and the
// sticky error flag is raised. Without the macro, error is tied low.
// -----------------------------------------------------------------------------
module lab_router_config_loader #(
    parameter  int CONFIG_BITS = 144,
    localparam int COUNT_WIDTH = $clog2(CONFIG_BITS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    output logic                   bit_ready,
    output logic [CONFIG_BITS-1:0] config_out,
    output logic                   config_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    // ST_PARITY is only reachable when the parity feature is compiled in.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_PARITY = 2'd3
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(CONFIG_BITS - 1);

    state_t                  r_state;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic [CONFIG_BITS-1:0]  r_shadow;

`ifdef LAB_ROUTER_CONFIG_PARITY_EN
    logic                    r_error;

    // Even parity: the data bits together with the parity bit must XOR to 0.
    function automatic logic f_parity_ok(input logic [CONFIG_BITS-1:0] data,
                                         input logic                   par);
        return ~((^data) ^ par);
    endfunction

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    // The loader is ready for a bit only while it is collecting a frame.
    assign bit_ready = (r_state == ST_SHIFT) || (r_state == ST_PARITY);

    // Load sequencer: collects bits into the shadow and commits whole frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_shadow     <= '0;
            config_out   <= '0;
            config_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef LAB_ROUTER_CONFIG_PARITY_EN
            r_error      <= 1'b0;
`endif
        end else begin
            // done is a pulse; only the COMMIT branch raises it again.
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // abort is deliberately not looked at here, so start wins.
                    if (start) begin
                        r_state  <= ST_SHIFT;
                        r_count  <= '0;
                        r_shadow <= '0;
                        busy     <= 1'b1;
`ifdef LAB_ROUTER_CONFIG_PARITY_EN
                        r_error  <= 1'b0;
`endif
                    end
                end

                ST_SHIFT: begin
                    // abort takes priority over a bit offered in the same cycle.
                    if (abort) begin
                        r_state  <= ST_IDLE;
                        r_count  <= '0;
                        r_shadow <= '0;
                        busy     <= 1'b0;
                    end else if (bit_valid) begin
                        // First bit received ends up in the MSB.
                        r_shadow <= {r_shadow[CONFIG_BITS-2:0], bit_in};
                        r_count  <= r_count + COUNT_WIDTH'(1);
                        if (r_count == LAST_IDX) begin
`ifdef LAB_ROUTER_CONFIG_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_COMMIT;
`endif
                        end
                    end
                end

`ifdef LAB_ROUTER_CONFIG_PARITY_EN
                ST_PARITY: begin
                    if (abort) begin
                        r_state  <= ST_IDLE;
                        r_count  <= '0;
                        r_shadow <= '0;
                        busy     <= 1'b0;
                    end else if (bit_valid) begin
                        if (f_parity_ok(r_shadow, bit_in)) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            // Bad frame: drop it, keep the old configuration.
                            r_state <= ST_IDLE;
                            r_error <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end
                end
`endif

                ST_COMMIT: begin
                    config_out   <= r_shadow;
                    config_valid <= 1'b1;
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    r_state      <= ST_IDLE;
                end

                default: begin
                    // Unreachable encodings recover to a quiet idle.
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lab_router_config_loader.sv
// -----------------------------------------------------------------------------
// Self-checking bench for lab_router_config_loader (CONFIG_BITS = 8).
// Builds with or without LAB_ROUTER_CONFIG_PARITY_EN; in the parity build every
// frame is followed by its even parity bit.
// -----------------------------------------------------------------------------
module tb_lab_router_config_loader;

    localparam int CB = 8;
`ifdef LAB_ROUTER_CONFIG_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, start, abort, bit_in, bit_valid;
    logic          bit_ready, config_valid, busy, done, error;
    logic [CB-1:0] config_out;

    int checks   = 0;
    int failures = 0;

    lab_router_config_loader #(.CONFIG_BITS(CB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .config_out(config_out), .config_valid(config_valid),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: frame value from the bit sequence, first bit is the MSB.
    function automatic logic [CB-1:0] assemble(input bit b[$]);
        logic [CB-1:0] v;
        v = '0;
        foreach (b[i]) v[CB-1-i] = b[i];
        return v;
    endfunction

    task automatic start_load();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer the first n bits of data (MSB first) with bit_valid held high.
    task automatic send_bits(input logic [CB-1:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            bit_in    = data[CB-1-i];
            tick();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Parity build only: offer the even parity bit, optionally corrupted.
    task automatic send_tail(input logic [CB-1:0] data, input bit flip);
        if (PAR) begin
            bit_valid = 1'b1;
            bit_in    = (^data) ^ flip;
            tick();
            bit_valid = 1'b0;
            bit_in    = 1'b0;
        end
    endtask

    // Count further edges until done appears (bounded).
    task automatic wait_commit(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 6) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        checks++; if (config_out !== 8'h00) begin failures++; $display("FAIL reset_cfg: got %h want 00", config_out); end
        checks++; if (config_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", config_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (bit_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", bit_ready); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b want 0", error); end
    endtask

    task automatic test_full_load();
        int lat;
        start_load();
        checks++; if (busy !== 1'b1 || bit_ready !== 1'b1) begin failures++; $display("FAIL load_busy: got busy=%b ready=%b want 1 1", busy, bit_ready); end
        send_bits(8'hB2, CB);
        send_tail(8'hB2, 1'b0);
        // Last bit just accepted: nothing committed yet.
        checks++; if (done !== 1'b0 || config_out !== 8'h00) begin failures++; $display("FAIL load_early: got done=%b cfg=%h want 0 00", done, config_out); end
        wait_commit(lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL load_latency: got %0d want 1", lat); end
        checks++; if (config_out !== 8'hB2) begin failures++; $display("FAIL load_cfg: got %h want b2", config_out); end
        checks++; if (config_valid !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL load_flags: got valid=%b busy=%b err=%b want 1 0 0", config_valid, busy, error); end
        tick();
        checks++; if (done !== 1'b0 || bit_ready !== 1'b0) begin failures++; $display("FAIL load_pulse: got done=%b ready=%b want 0 0", done, bit_ready); end
    endtask

    task automatic test_stall();
        int lat;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        start_load();
        send_bits(8'hB2, 4);
        // Stall with junk on bit_in; none of it may enter the frame.
        for (int i = 0; i < 3; i++) begin
            bit_in = 1'b1;
            tick();
            checks++; if (bit_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL stall_ready: got ready=%b busy=%b want 1 1", bit_ready, busy); end
        end
        for (int i = 4; i < CB; i++) begin
            bit_valid = 1'b1; bit_in = (8'hB2 >> (CB-1-i)) & 1; tick();
        end
        bit_valid = 1'b0;
        send_tail(8'hB2, 1'b0);
        wait_commit(lat);
        checks++; if (config_out !== 8'hB2 || lat !== 1) begin failures++; $display("FAIL stall_cfg: got %h lat=%0d want b2 lat=1", config_out, lat); end
        tick();
        checks++; if (bit_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL stall_idle: got ready=%b done=%b want 0 0", bit_ready, done); end
    endtask

    task automatic test_abort_reload();
        int lat;
        int seen;
        start_load();
        send_bits(8'h5C, 5);
        abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        abort = 1'b0; bit_valid = 1'b0;
        checks++; if (busy !== 1'b0 || bit_ready !== 1'b0) begin failures++; $display("FAIL abort_idle: got busy=%b ready=%b want 0 0", busy, bit_ready); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        checks++; if (seen !== 0 || config_out !== 8'hB2) begin failures++; $display("FAIL abort_hold: got done_seen=%0d cfg=%h want 0 b2", seen, config_out); end
        // abort alone in IDLE does nothing.
        abort = 1'b1; tick(); abort = 1'b0;
        checks++; if (busy !== 1'b0 || config_valid !== 1'b1) begin failures++; $display("FAIL abort_in_idle: got busy=%b valid=%b want 0 1", busy, config_valid); end
        // start and abort together in IDLE: start wins.
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b1 || bit_ready !== 1'b1) begin failures++; $display("FAIL start_wins: got busy=%b ready=%b want 1 1", busy, bit_ready); end
        send_bits(8'h0F, CB);
        send_tail(8'h0F, 1'b0);
        wait_commit(lat);
        checks++; if (config_out !== 8'h0F || lat !== 1) begin failures++; $display("FAIL reload_cfg: got %h lat=%0d want 0f lat=1", config_out, lat); end
        tick();
    endtask

    task automatic test_random_loads();
        bit            q[$];
        logic [CB-1:0] exp;
        logic [CB-1:0] prev;
        int            idx, cyc, lat;
        for (int f = 0; f < 6; f++) begin
            q.delete();
            for (int i = 0; i < CB; i++) q.push_back(1'($urandom_range(0, 1)));
            exp  = assemble(q);
            prev = config_out;
            start_load();
            idx = 0; cyc = 0;
            while (idx < CB && cyc < 200) begin
                bit_valid = 1'($urandom_range(0, 1));
                start     = 1'($urandom_range(0, 1));
                bit_in    = bit_valid ? q[idx] : 1'($urandom_range(0, 1));
                checks++; if (bit_ready !== 1'b1 || config_out !== prev) begin failures++; $display("FAIL rnd_loading: got ready=%b cfg=%h want 1 %h", bit_ready, config_out, prev); end
                tick();
                if (bit_valid) idx++;
                cyc++;
            end
            bit_valid = 1'b0; start = 1'b0;
            send_tail(exp, 1'b0);
            wait_commit(lat);
            checks++; if (config_out !== exp || lat !== 1) begin failures++; $display("FAIL rnd_cfg: frame %0d got %h lat=%0d want %h lat=1", f, config_out, lat, exp); end
            tick();
        end
    endtask

`ifdef LAB_ROUTER_CONFIG_PARITY_EN
    task automatic test_parity();
        int lat;
        int seen;
        start_load();
        send_bits(8'hB2, CB);
        send_tail(8'hB2, 1'b0);
        wait_commit(lat);
        checks++; if (config_out !== 8'hB2 || error !== 1'b0 || lat !== 1) begin failures++; $display("FAIL par_good: got cfg=%h err=%b lat=%0d want b2 0 1", config_out, error, lat); end
        tick();
        for (int k = 0; k < 2; k++) begin
            start_load();
            send_bits(k == 0 ? 8'hB2 : 8'h5A, CB);
            send_tail(k == 0 ? 8'hB2 : 8'h5A, 1'b1);
            seen = 0;
            for (int i = 0; i < 3; i++) begin
                if (done === 1'b1) seen++;
                tick();
            end
            checks++; if (seen !== 0 || config_out !== 8'hB2) begin failures++; $display("FAIL par_bad_hold: got done_seen=%0d cfg=%h want 0 b2", seen, config_out); end
            checks++; if (error !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL par_bad_err: got err=%b busy=%b want 1 0", error, busy); end
        end
        start_load();
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL par_clear: got err=%b want 0", error); end
        send_bits(8'h0F, CB);
        send_tail(8'h0F, 1'b0);
        wait_commit(lat);
        checks++; if (config_out !== 8'h0F) begin failures++; $display("FAIL par_reload: got %h want 0f", config_out); end
        tick();
    endtask
`endif

    task automatic test_reset_midload();
        int lat;
        start_load();
        send_bits(8'hB2, CB);
        send_tail(8'hB2, 1'b0);
        wait_commit(lat);
        tick();
        checks++; if (config_out !== 8'hB2) begin failures++; $display("FAIL rstmid_pre: got %h want b2", config_out); end
        start_load();
        send_bits(8'h3C, 3);
        rst_n = 1'b0; start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        rst_n = 1'b1; start = 1'b0; bit_valid = 1'b0;
        checks++; if (config_out !== 8'h00 || config_valid !== 1'b0) begin failures++; $display("FAIL rstmid_cfg: got cfg=%h valid=%b want 00 0", config_out, config_valid); end
        checks++; if (busy !== 1'b0 || bit_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_idle: got busy=%b ready=%b done=%b want 0 0 0", busy, bit_ready, done); end
        tick();
        checks++; if (busy !== 1'b0 || bit_ready !== 1'b0) begin failures++; $display("FAIL rstmid_start_ignored: got busy=%b ready=%b want 0 0", busy, bit_ready); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        test_reset();
        test_full_load();
        test_stall();
        test_abort_reload();
        test_random_loads();
`ifdef LAB_ROUTER_CONFIG_PARITY_EN
        test_parity();
`endif
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
